// File: rtl/pcpi_initiator_if.sv
// Bundles the command, PCPI and response signals of the PCPI initiator.
// The master modport is the initiator side; the slave modport is its environment.
interface pcpi_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_wr;
    logic        rsp_timeout;

    logic [15:0] stat_done;
    logic [15:0] stat_timeout;

    modport master (
        input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  rsp_ready,
        output cmd_ready,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output rsp_valid, rsp_rd, rsp_wr, rsp_timeout,
        output stat_done, stat_timeout
    );

    modport slave (
        output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output rsp_ready,
        input  cmd_ready,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  rsp_valid, rsp_rd, rsp_wr, rsp_timeout,
        input  stat_done, stat_timeout
    );
endinterface

// File: rtl/pcpi_initiator.sv
// CPU-side PCPI initiator: issues one custom instruction at a time, waits for
// pcpi_ready (or times out) and hands the result back over a valid/ready port.
module pcpi_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    pcpi_initiator_if.master  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic [31:0] pcpi_insn_q, pcpi_insn_d;
    logic [31:0] pcpi_rs1_q, pcpi_rs1_d;
    logic [31:0] pcpi_rs2_q, pcpi_rs2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [15:0] stat_done_q, stat_done_d;
    logic [15:0] stat_timeout_q, stat_timeout_d;
    logic [7:0]  count_q, count_d;
    logic        cmd_ready_w;

    assign cmd_ready_w = (state_q == IDLE) && resetn;

    always_comb begin
        state_d        = state_q;
        pcpi_valid_d   = pcpi_valid_q;
        pcpi_insn_d    = pcpi_insn_q;
        pcpi_rs1_d     = pcpi_rs1_q;
        pcpi_rs2_d     = pcpi_rs2_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rd_d       = rsp_rd_q;
        rsp_wr_d       = rsp_wr_q;
        rsp_timeout_d  = rsp_timeout_q;
        stat_done_d    = stat_done_q;
        stat_timeout_d = stat_timeout_q;
        count_d        = count_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_w) begin
                    pcpi_insn_d  = bus.cmd_insn;
                    pcpi_rs1_d   = bus.cmd_rs1;
                    pcpi_rs2_d   = bus.cmd_rs2;
                    pcpi_valid_d = 1'b1;
                    count_d      = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Ready outranks the timeout so a last-cycle answer still counts as done.
                if (bus.pcpi_ready) begin
                    rsp_rd_d      = bus.pcpi_wr ? bus.pcpi_rd : 32'd0;
                    rsp_wr_d      = bus.pcpi_wr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    pcpi_valid_d  = 1'b0;
                    stat_done_d   = stat_done_q + 16'd1;
                    state_d       = RESP;
                end else if (bus.pcpi_wait) begin
                    count_d = '0;
                end else if (count_q == LAST_COUNT) begin
                    rsp_rd_d       = 32'd0;
                    rsp_wr_d       = 1'b0;
                    rsp_timeout_d  = 1'b1;
                    rsp_valid_d    = 1'b1;
                    pcpi_valid_d   = 1'b0;
                    stat_timeout_d = (stat_timeout_q == 16'hFFFF) ? stat_timeout_q
                                                                  : stat_timeout_q + 16'd1;
                    state_d        = RESP;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            pcpi_valid_q   <= 1'b0;
            pcpi_insn_q    <= '0;
            pcpi_rs1_q     <= '0;
            pcpi_rs2_q     <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rd_q       <= '0;
            rsp_wr_q       <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            stat_done_q    <= '0;
            stat_timeout_q <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            pcpi_valid_q   <= pcpi_valid_d;
            pcpi_insn_q    <= pcpi_insn_d;
            pcpi_rs1_q     <= pcpi_rs1_d;
            pcpi_rs2_q     <= pcpi_rs2_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rd_q       <= rsp_rd_d;
            rsp_wr_q       <= rsp_wr_d;
            rsp_timeout_q  <= rsp_timeout_d;
            stat_done_q    <= stat_done_d;
            stat_timeout_q <= stat_timeout_d;
            count_q        <= count_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_w;
    assign bus.pcpi_valid   = pcpi_valid_q;
    assign bus.pcpi_insn    = pcpi_insn_q;
    assign bus.pcpi_rs1     = pcpi_rs1_q;
    assign bus.pcpi_rs2     = pcpi_rs2_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rd       = rsp_rd_q;
    assign bus.rsp_wr       = rsp_wr_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.stat_done    = stat_done_q;
    assign bus.stat_timeout = stat_timeout_q;
endmodule

// File: tb/tb_pcpi_initiator.sv
// Directed bench for pcpi_initiator with a Sigma0 responder model and a
// manually driven responder stub for wait, collision and stall scenarios.
module tb_pcpi_initiator;
    logic clk;
    logic resetn;
    int   tests_run;
    int   tests_failed;

    logic        use_stub;
    logic        stub_ready;
    logic        stub_wait;
    logic        stub_wr;
    logic [31:0] stub_rd;
    logic        sigma_claim;
    logic [31:0] sigma_val;

    pcpi_initiator_if bus ();

    pcpi_initiator #(.TIMEOUT(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sigma0 responder: claims custom-0 with funct3=0 and funct7=0 and answers at once.
    assign sigma_claim = bus.pcpi_valid && (bus.pcpi_insn[6:0] == 7'h0B) &&
                         (bus.pcpi_insn[14:12] == 3'd0) && (bus.pcpi_insn[31:25] == 7'd0);
    assign sigma_val   = {bus.pcpi_rs1[1:0],  bus.pcpi_rs1[31:2]}  ^
                         {bus.pcpi_rs1[12:0], bus.pcpi_rs1[31:13]} ^
                         {bus.pcpi_rs1[21:0], bus.pcpi_rs1[31:22]};

    assign bus.pcpi_ready = use_stub ? stub_ready : sigma_claim;
    assign bus.pcpi_wait  = use_stub ? stub_wait  : 1'b0;
    assign bus.pcpi_wr    = use_stub ? stub_wr    : sigma_claim;
    assign bus.pcpi_rd    = use_stub ? stub_rd    : sigma_val;

    task automatic do_reset();
        @(negedge clk);
        resetn        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        use_stub      = 1'b0;
        stub_ready    = 1'b0;
        stub_wait     = 1'b0;
        stub_wr       = 1'b0;
        stub_rd       = 32'd0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic issue_cmd(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = insn;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic consume_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn        = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout, bus.cmd_ready} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout, bus.cmd_ready});
        end
        tests_run++;
        if ({bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2, bus.rsp_rd, bus.stat_done, bus.stat_timeout} !== 160'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: insn %h rs1 %h rs2 %h rd %h done %h tmo %h, all required 0",
                     bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2, bus.rsp_rd, bus.stat_done, bus.stat_timeout);
        end
        bus.cmd_valid = 1'b0;
        resetn = 1'b1;
        #1;
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_sigma0();
        do_reset();
        issue_cmd(32'h0000000B, 32'h00000001, 32'h00000000);
        tests_run++;
        if ({bus.pcpi_valid, bus.cmd_ready, bus.rsp_valid, bus.pcpi_insn, bus.pcpi_rs1} !== {3'b100, 32'h0000000B, 32'h00000001}) begin
            tests_failed++;
            $display("[TB] FAIL sigma0_busy: valid/ready/rsp %b%b%b insn %h rs1 %h expected 100 0000000b 00000001",
                     bus.pcpi_valid, bus.cmd_ready, bus.rsp_valid, bus.pcpi_insn, bus.pcpi_rs1);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout} !== 4'b0110) begin
            tests_failed++;
            $display("[TB] FAIL sigma0_flags: got %b expected 0110",
                     {bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout});
        end
        tests_run++;
        if ({bus.rsp_rd, bus.stat_done, bus.stat_timeout} !== {32'h40080400, 16'd1, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL sigma0_result: rd %h done %0d tmo %0d expected 40080400 1 0",
                     bus.rsp_rd, bus.stat_done, bus.stat_timeout);
        end
        consume_rsp();
        tests_run++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL sigma0_return_idle: rsp_valid/cmd_ready %b expected 01",
                     {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_timeout();
        int n;
        logic unstable;
        do_reset();
        issue_cmd(32'h0000100B, 32'h12345678, 32'hCAFEF00D);
        bus.cmd_insn = 32'hFFFFFFFF;
        bus.cmd_rs1  = 32'hFFFFFFFF;
        bus.cmd_rs2  = 32'hFFFFFFFF;
        n = 0;
        unstable = 1'b0;
        while (bus.pcpi_valid === 1'b1 && n < 100) begin
            if ({bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2} !== {32'h0000100B, 32'h12345678, 32'hCAFEF00D})
                unstable = 1'b1;
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 16) begin
            tests_failed++;
            $display("[TB] FAIL timeout_valid_cycles: got %0d expected 16", n);
        end
        tests_run++;
        if (unstable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_operands_stable: got unstable=%b expected 0", unstable);
        end
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout, bus.rsp_rd, bus.stat_timeout, bus.stat_done} !==
            {3'b101, 32'd0, 16'd1, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_rsp: valid/wr/tmo %b rd %h stat_tmo %0d stat_done %0d expected 101 0 1 0",
                     {bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout}, bus.rsp_rd, bus.stat_timeout, bus.stat_done);
        end
        consume_rsp();
    endtask

    task automatic test_wait();
        logic broke;
        do_reset();
        use_stub = 1'b1;
        issue_cmd(32'h0000200B, 32'h00000005, 32'h00000006);
        stub_wait = 1'b1;
        broke = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.pcpi_valid !== 1'b1 || bus.rsp_valid !== 1'b0) broke = 1'b1;
        end
        tests_run++;
        if (broke !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wait_holds_busy: got ended=%b expected 0", broke);
        end
        stub_wait  = 1'b0;
        stub_ready = 1'b1;
        stub_wr    = 1'b1;
        stub_rd    = 32'hDEADBEEF;
        @(negedge clk);
        stub_ready = 1'b0;
        stub_wr    = 1'b0;
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout, bus.rsp_rd, bus.stat_done, bus.stat_timeout} !==
            {3'b110, 32'hDEADBEEF, 16'd1, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL wait_rsp: valid/wr/tmo %b rd %h done %0d tmo %0d expected 110 deadbeef 1 0",
                     {bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout}, bus.rsp_rd, bus.stat_done, bus.stat_timeout);
        end
        consume_rsp();
    endtask

    task automatic test_back_to_back();
        logic moved;
        do_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd_insn  = 32'h0000000B;
        bus.cmd_rs1   = 32'h80000000;
        bus.cmd_rs2   = 32'h0;
        @(negedge clk);
        bus.cmd_rs1 = 32'h00000001;
        @(negedge clk);
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout, bus.cmd_ready, bus.rsp_rd} !== {4'b1100, 32'h20040200})
                moved = 1'b1;
            if (i < 4) @(negedge clk);
        end
        tests_run++;
        if (moved !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_stable: got changed=%b expected 0 (last rd %h)", moved, bus.rsp_rd);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        tests_run++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.pcpi_valid} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle: rsp_valid/cmd_ready/pcpi_valid %b expected 010",
                     {bus.rsp_valid, bus.cmd_ready, bus.pcpi_valid});
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests_run++;
        if ({bus.pcpi_valid, bus.pcpi_rs1} !== {1'b1, 32'h00000001}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_accept: valid %b rs1 %h expected 1 00000001", bus.pcpi_valid, bus.pcpi_rs1);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_rd, bus.stat_done} !== {1'b1, 32'h40080400, 16'd2}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_rsp: valid %b rd %h done %0d expected 1 40080400 2",
                     bus.rsp_valid, bus.rsp_rd, bus.stat_done);
        end
        consume_rsp();
    endtask

    task automatic test_collision();
        do_reset();
        use_stub = 1'b1;
        issue_cmd(32'h0000300B, 32'h0000000A, 32'h0000000B);
        for (int i = 0; i < 15; i++) @(negedge clk);
        tests_run++;
        if ({bus.pcpi_valid, bus.rsp_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL collision_cycle16_busy: pcpi_valid/rsp_valid %b expected 10",
                     {bus.pcpi_valid, bus.rsp_valid});
        end
        stub_ready = 1'b1;
        stub_wr    = 1'b1;
        stub_rd    = 32'h00001234;
        @(negedge clk);
        stub_ready = 1'b0;
        stub_wr    = 1'b0;
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_wr, bus.rsp_rd, bus.stat_done, bus.stat_timeout} !==
            {3'b101, 32'h00001234, 16'd1, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL collision_ready_wins: valid/tmo/wr %b rd %h done %0d tmo %0d expected 101 00001234 1 0",
                     {bus.rsp_valid, bus.rsp_timeout, bus.rsp_wr}, bus.rsp_rd, bus.stat_done, bus.stat_timeout);
        end
        consume_rsp();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        issue_cmd(32'h0000000B, 32'h00000001, 32'h0);
        @(negedge clk);
        consume_rsp();
        use_stub = 1'b1;
        issue_cmd(32'h0000400B, 32'h00000077, 32'h00000088);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.pcpi_valid, bus.rsp_valid, bus.stat_done, bus.stat_timeout} !== {2'b00, 16'd0, 16'd0}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_cleared: valid %b rsp %b done %0d tmo %0d expected 0 0 0 0",
                     bus.pcpi_valid, bus.rsp_valid, bus.stat_done, bus.stat_timeout);
        end
        resetn = 1'b1;
        use_stub = 1'b0;
        #1;
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        @(negedge clk);
        issue_cmd(32'h0000000B, 32'h00000001, 32'h0);
        @(negedge clk);
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout, bus.rsp_rd, bus.stat_done} !==
            {3'b110, 32'h40080400, 16'd1}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_new_cmd: valid/wr/tmo %b rd %h done %0d expected 110 40080400 1",
                     {bus.rsp_valid, bus.rsp_wr, bus.rsp_timeout}, bus.rsp_rd, bus.stat_done);
        end
        consume_rsp();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        resetn        = 1'b0;
        use_stub      = 1'b0;
        stub_ready    = 1'b0;
        stub_wait     = 1'b0;
        stub_wr       = 1'b0;
        stub_rd       = 32'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_insn  = 32'd0;
        bus.cmd_rs1   = 32'd0;
        bus.cmd_rs2   = 32'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_sigma0();
        test_timeout();
        test_wait();
        test_back_to_back();
        test_collision();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
